// File: rtl/id_imm_gen_pkg.sv
// Shared constants for the decode-stage immediate generator: widths, opcode
// values, immediate-mux select codes and the opcode classifier.
package id_imm_gen_pkg;

    localparam int INST_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int OPCODE_W   = 5;

    typedef enum logic [2:0] {
        IM_S_E_3_0  = 3'd0,
        IM_S_E_4_0  = 3'd1,
        IM_S_E_7_0  = 3'd2,
        IM_S_E_10_0 = 3'd3,
        IM_Z_E_7_0  = 3'd4,
        IM_NONE     = 3'd7
    } im_mux_op_e;

    localparam logic [OPCODE_W-1:0] OP_B      = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_BEQZ   = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_BNEZ   = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_ADDIU3 = 5'b01000;
    localparam logic [OPCODE_W-1:0] OP_ADDIU  = 5'b01001;
    localparam logic [OPCODE_W-1:0] OP_SPGRP  = 5'b01100;
    localparam logic [OPCODE_W-1:0] OP_LI     = 5'b01101;
    localparam logic [OPCODE_W-1:0] OP_CMPI   = 5'b01110;
    localparam logic [OPCODE_W-1:0] OP_LW_SP  = 5'b10010;
    localparam logic [OPCODE_W-1:0] OP_LW     = 5'b10011;
    localparam logic [OPCODE_W-1:0] OP_SW_SP  = 5'b11010;
    localparam logic [OPCODE_W-1:0] OP_SW     = 5'b11011;

    localparam logic [DATA_W_DEF-1:0] EMPTY_DATA = 16'h0000;

    // Unlisted opcodes select IM_NONE, which the EX mux turns into zero.
    function automatic im_mux_op_e classify_opcode(input logic [OPCODE_W-1:0] opcode);
        im_mux_op_e op;
        op = IM_NONE;
        case (opcode)
            OP_ADDIU3:                    op = IM_S_E_3_0;
            OP_LW, OP_SW:                 op = IM_S_E_4_0;
            OP_ADDIU, OP_SPGRP, OP_BEQZ,
            OP_BNEZ, OP_LW_SP, OP_SW_SP,
            OP_CMPI:                      op = IM_S_E_7_0;
            OP_B:                         op = IM_S_E_10_0;
            OP_LI:                        op = IM_Z_E_7_0;
            default:                      op = IM_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_imm_gen_field_decode.sv
// Combinational field decoder: opcode class plus all extended immediates,
// computed unconditionally from the instruction bits.
module im_field_decode
    import id_imm_gen_pkg::*;
#(
    parameter int INST_W = INST_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [INST_W-1:0] inst,
    output logic [2:0]        op,
    output logic [DATA_W-1:0] s_e3_0,
    output logic [DATA_W-1:0] s_e4_0,
    output logic [DATA_W-1:0] s_e7_0,
    output logic [DATA_W-1:0] s_e10_0,
    output logic [DATA_W-1:0] z_e7_0
);

    logic [OPCODE_W-1:0] opcode_s;

    assign opcode_s = inst[INST_W-1 -: OPCODE_W];

    // Classify opcode and build each immediate from its field MSB.
    always_comb begin
        op      = 3'd7;
        s_e3_0  = {DATA_W{1'b0}};
        s_e4_0  = {DATA_W{1'b0}};
        s_e7_0  = {DATA_W{1'b0}};
        s_e10_0 = {DATA_W{1'b0}};
        z_e7_0  = {DATA_W{1'b0}};

        op      = classify_opcode(opcode_s);
        s_e3_0  = {{(DATA_W-4){inst[3]}},   inst[3:0]};
        s_e4_0  = {{(DATA_W-5){inst[4]}},   inst[4:0]};
        s_e7_0  = {{(DATA_W-8){inst[7]}},   inst[7:0]};
        s_e10_0 = {{(DATA_W-11){inst[10]}}, inst[10:0]};
        z_e7_0  = {{(DATA_W-8){1'b0}},      inst[7:0]};
    end

endmodule

// File: rtl/id_imm_gen.sv
// ID/EX pipeline register around im_field_decode: one-cycle latency with
// flush > stall > load priority; invalid slots become zeroed bubbles.
module id_imm_gen
    import id_imm_gen_pkg::*;
#(
    parameter int INST_W = INST_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] if_inst,
    input  logic              if_valid,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [INST_W-1:0] ex_inst,
    output logic [2:0]        im_mux_op,
    output logic [DATA_W-1:0] im_s_e3_0,
    output logic [DATA_W-1:0] im_s_e4_0,
    output logic [DATA_W-1:0] im_s_e7_0,
    output logic [DATA_W-1:0] im_s_e10_0,
    output logic [DATA_W-1:0] im_z_e7_0
);

    localparam logic [2:0] OP_BUBBLE = 3'd7;

    logic [2:0]        dec_op_s;
    logic [DATA_W-1:0] dec_s3_s, dec_s4_s, dec_s7_s, dec_s10_s, dec_z7_s;

    logic              valid_r,  valid_nxt_s;
    logic [INST_W-1:0] inst_r,   inst_nxt_s;
    logic [2:0]        op_r,     op_nxt_s;
    logic [DATA_W-1:0] s3_r,     s3_nxt_s;
    logic [DATA_W-1:0] s4_r,     s4_nxt_s;
    logic [DATA_W-1:0] s7_r,     s7_nxt_s;
    logic [DATA_W-1:0] s10_r,    s10_nxt_s;
    logic [DATA_W-1:0] z7_r,     z7_nxt_s;

    im_field_decode #(
        .INST_W (INST_W),
        .DATA_W (DATA_W)
    ) u_decode (
        .inst    (if_inst),
        .op      (dec_op_s),
        .s_e3_0  (dec_s3_s),
        .s_e4_0  (dec_s4_s),
        .s_e7_0  (dec_s7_s),
        .s_e10_0 (dec_s10_s),
        .z_e7_0  (dec_z7_s)
    );

    // Next-state selection: bubble on flush or empty slot, hold on stall.
    always_comb begin
        valid_nxt_s = valid_r;
        inst_nxt_s  = inst_r;
        op_nxt_s    = op_r;
        s3_nxt_s    = s3_r;
        s4_nxt_s    = s4_r;
        s7_nxt_s    = s7_r;
        s10_nxt_s   = s10_r;
        z7_nxt_s    = z7_r;

        if (flush || (!stall && !if_valid)) begin
            valid_nxt_s = 1'b0;
            inst_nxt_s  = {INST_W{1'b0}};
            op_nxt_s    = OP_BUBBLE;
            s3_nxt_s    = {DATA_W{1'b0}};
            s4_nxt_s    = {DATA_W{1'b0}};
            s7_nxt_s    = {DATA_W{1'b0}};
            s10_nxt_s   = {DATA_W{1'b0}};
            z7_nxt_s    = {DATA_W{1'b0}};
        end else if (!stall) begin
            valid_nxt_s = 1'b1;
            inst_nxt_s  = if_inst;
            op_nxt_s    = dec_op_s;
            s3_nxt_s    = dec_s3_s;
            s4_nxt_s    = dec_s4_s;
            s7_nxt_s    = dec_s7_s;
            s10_nxt_s   = dec_s10_s;
            z7_nxt_s    = dec_z7_s;
        end else begin
            valid_nxt_s = valid_r;
            inst_nxt_s  = inst_r;
        end
    end

    // ID/EX state register with asynchronous reset to the bubble state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            inst_r  <= {INST_W{1'b0}};
            op_r    <= OP_BUBBLE;
            s3_r    <= {DATA_W{1'b0}};
            s4_r    <= {DATA_W{1'b0}};
            s7_r    <= {DATA_W{1'b0}};
            s10_r   <= {DATA_W{1'b0}};
            z7_r    <= {DATA_W{1'b0}};
        end else begin
            valid_r <= valid_nxt_s;
            inst_r  <= inst_nxt_s;
            op_r    <= op_nxt_s;
            s3_r    <= s3_nxt_s;
            s4_r    <= s4_nxt_s;
            s7_r    <= s7_nxt_s;
            s10_r   <= s10_nxt_s;
            z7_r    <= z7_nxt_s;
        end
    end

    assign ex_valid   = valid_r;
    assign ex_inst    = inst_r;
    assign im_mux_op  = op_r;
    assign im_s_e3_0  = s3_r;
    assign im_s_e4_0  = s4_r;
    assign im_s_e7_0  = s7_r;
    assign im_s_e10_0 = s10_r;
    assign im_z_e7_0  = z7_r;

endmodule

// File: tb/tb_id_imm_gen.sv
// Self-checking bench for id_imm_gen: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_id_imm_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] if_inst;
    logic        if_valid, stall, flush;
    logic        ex_valid;
    logic [15:0] ex_inst;
    logic [2:0]  im_mux_op;
    logic [15:0] im_s_e3_0, im_s_e4_0, im_s_e7_0, im_s_e10_0, im_z_e7_0;

    int n_vec = 0;
    int n_err = 0;

    // Model of the ID/EX slot: only validity and instruction are tracked.
    bit          m_valid;
    logic [15:0] m_inst;

    id_imm_gen #(.INST_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .if_inst(if_inst), .if_valid(if_valid),
        .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_inst(ex_inst),
        .im_mux_op(im_mux_op), .im_s_e3_0(im_s_e3_0), .im_s_e4_0(im_s_e4_0),
        .im_s_e7_0(im_s_e7_0), .im_s_e10_0(im_s_e10_0), .im_z_e7_0(im_z_e7_0)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sx(input int unsigned f, input int n);
        int s;
        s = int'(f);
        if (f >= (32'd1 << (n - 1))) s = s - (1 << n);
        return 16'(s);
    endfunction

    function automatic logic [2:0] ref_op(input logic [15:0] inst);
        logic [4:0] oc;
        oc = inst[15:11];
        if (oc == 5'b01000) return 3'd0;
        if (oc inside {5'b10011, 5'b11011}) return 3'd1;
        if (oc inside {5'b01001, 5'b01100, 5'b00100, 5'b00101,
                       5'b10010, 5'b11010, 5'b01110}) return 3'd2;
        if (oc == 5'b00010) return 3'd3;
        if (oc == 5'b01101) return 3'd4;
        return 3'd7;
    endfunction

    function automatic logic [99:0] ref_vec(input bit v, input logic [15:0] inst);
        if (!v) return {1'b0, 16'h0000, 3'd7, 80'h0};
        return {1'b1, inst, ref_op(inst),
                sx(int'(inst) % 16, 4), sx(int'(inst) % 32, 5),
                sx(int'(inst) % 256, 8), sx(int'(inst) % 2048, 11),
                16'(int'(inst) % 256)};
    endfunction

    function automatic logic [99:0] dut_vec();
        return {ex_valid, ex_inst, im_mux_op, im_s_e3_0, im_s_e4_0,
                im_s_e7_0, im_s_e10_0, im_z_e7_0};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0; m_inst = 16'h0000;
        end else if (!stall) begin
            m_valid = if_valid;
            m_inst  = if_valid ? if_inst : 16'h0000;
        end
        #1;
    endtask

    task automatic drive(input logic [15:0] i, input bit v, input bit s, input bit f);
        if_inst = i; if_valid = v; stall = s; flush = f;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(16'h0000, 1'b0, 1'b0, 1'b0);
        m_valid = 1'b0; m_inst = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (dut_vec() !== ref_vec(1'b0, 16'h0000)) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", dut_vec(), ref_vec(1'b0, 16'h0000));
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        drive(16'h410F, 1'b1, 1'b0, 1'b0); tick();
        n_vec++;
        if ({ex_valid, im_mux_op, im_s_e3_0, im_s_e4_0} !== {1'b1, 3'd0, 16'hFFFF, 16'h000F}) begin
            n_err++;
            $display("FAIL addiu3: got %b %0d %h %h want 1 0 ffff 000f",
                     ex_valid, im_mux_op, im_s_e3_0, im_s_e4_0);
        end
        drive(16'h68A5, 1'b1, 1'b0, 1'b0); tick();
        n_vec++;
        if ({im_mux_op, im_z_e7_0, im_s_e7_0} !== {3'd4, 16'h00A5, 16'hFFA5}) begin
            n_err++;
            $display("FAIL li: got %0d %h %h want 4 00a5 ffa5", im_mux_op, im_z_e7_0, im_s_e7_0);
        end
        drive(16'h1400, 1'b1, 1'b0, 1'b0); tick();
        n_vec++;
        if ({im_mux_op, im_s_e10_0} !== {3'd3, 16'hFC00}) begin
            n_err++;
            $display("FAIL b_neg: got %0d %h want 3 fc00", im_mux_op, im_s_e10_0);
        end
        drive(16'h1000, 1'b1, 1'b0, 1'b0); tick();
        n_vec++;
        if ({im_mux_op, im_s_e10_0} !== {3'd3, 16'h0000}) begin
            n_err++;
            $display("FAIL b_zero: got %0d %h want 3 0000", im_mux_op, im_s_e10_0);
        end
    endtask

    task automatic test_stall();
        drive(16'h4904, 1'b1, 1'b0, 1'b0); tick();
        drive(16'h68FF, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({ex_valid, ex_inst, im_mux_op, im_s_e7_0} !== {1'b1, 16'h4904, 3'd2, 16'h0004}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got %b %h %0d %h want 1 4904 2 0004",
                         i, ex_valid, ex_inst, im_mux_op, im_s_e7_0);
            end
        end
        drive(16'h68FF, 1'b1, 1'b0, 1'b0); tick();
        n_vec++;
        if (dut_vec() !== ref_vec(1'b1, 16'h68FF)) begin
            n_err++;
            $display("FAIL stall_release: got %h want %h", dut_vec(), ref_vec(1'b1, 16'h68FF));
        end
    endtask

    task automatic test_flush();
        drive(16'h9BFF, 1'b1, 1'b1, 1'b1); tick();
        n_vec++;
        if (dut_vec() !== ref_vec(1'b0, 16'h0000)) begin
            n_err++;
            $display("FAIL flush_over_stall: got %h want %h", dut_vec(), ref_vec(1'b0, 16'h0000));
        end
        drive(16'h410F, 1'b1, 1'b0, 1'b0); tick();
        drive(16'h410F, 1'b0, 1'b0, 1'b0); tick();
        n_vec++;
        if (dut_vec() !== ref_vec(1'b0, 16'h0000)) begin
            n_err++;
            $display("FAIL invalid_bubble: got %h want %h", dut_vec(), ref_vec(1'b0, 16'h0000));
        end
    endtask

    task automatic test_async_reset();
        drive(16'h6A7F, 1'b1, 1'b0, 1'b0); tick();
        #1 rst = 1'b1;
        #1;
        m_valid = 1'b0; m_inst = 16'h0000;
        n_vec++;
        if (dut_vec() !== ref_vec(1'b0, 16'h0000)) begin
            n_err++;
            $display("FAIL async_reset: got %h want %h", dut_vec(), ref_vec(1'b0, 16'h0000));
        end
        #1 rst = 1'b0;
        drive(16'h2480, 1'b1, 1'b0, 1'b0); tick();
        n_vec++;
        if (dut_vec() !== ref_vec(1'b1, 16'h2480)) begin
            n_err++;
            $display("FAIL post_reset_load: got %h want %h", dut_vec(), ref_vec(1'b1, 16'h2480));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(16'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) == 0));
            tick();
            n_vec++;
            if (dut_vec() !== ref_vec(m_valid, m_inst)) begin
                n_err++;
                $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), ref_vec(m_valid, m_inst));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
